rv_seven_digit_device_mx: RTL and testbench
===========================================

Name: rv_seven_digit_device_mx

Overview:
- Memory-mapped seven-segment display controller on the core's data bus; next generation of the single-register hex display device.
- Generalised to NUM_DIGITS digits, with per-digit enable, per-digit blink, 16-level PWM brightness and a multiplexed scan output alongside the static per-digit outputs.
- Sits on the data-bus decoder at BASE_ADDR; drives board HEX displays (static) or a common-anode multiplexed module on GPIO (scan).

Parameters:
- NUM_DIGITS, 8, number of digits, legal range 1..8.
- BASE_ADDR, ADDRESS_HEX, 16-byte aligned base address of the register window.
- SCAN_DIV, 50000, clock cycles each digit is selected in scan mode; must be at least 1.
- BLINK_DIV_RST, 25000000, reset value of the BLINK_DIV register.

Ports:
- clk  in  1  clock
- arstn_i  in  1  asynchronous active-low reset
- data_req_i  in  1  bus request
- data_we_i  in  1  1 = write, 0 = read
- data_be_i  in  XLEN/8  byte enables
- data_addr_i  in  XLEN  byte address
- data_wdata_i  in  XLEN  write data
- data_rvalid_o  out  1  response valid
- data_rdata_o  out  XLEN  read data
- hex_o  out  NUM_DIGITS*7  static segments, active-low, digit 0 in bits [6:0]
- seg_o  out  7  scan segments, active-low
- dig_sel_o  out  NUM_DIGITS  scan digit select, one-hot, active-low

Behaviour:
- Reset: all registers go to their reset values.
  - hex_o, seg_o and dig_sel_o go to all ones (blank).
  - data_rvalid_o and data_rdata_o go to 0.
  - Blink, scan and PWM counters go to 0; blink phase goes to on.
- Request decode:
  - A request is accepted when data_req_i = 1 and data_addr_i[XLEN-1:4] equals BASE_ADDR[XLEN-1:4]. Any other request is ignored and produces no response.
  - Every accepted request asserts data_rvalid_o for exactly one cycle, on the next clock edge.
  - For a read, data_rdata_o carries the register value in that same cycle. For a write, data_rdata_o is 0.
  - Back-to-back requests on consecutive cycles are supported; there are no wait states.
- Registers, selected by data_addr_i[3:2]:
  - 0 DATA (rw, reset 0): nibble i is the hex value of digit i. Bits above NUM_DIGITS*4 read as 0.
  - 1 CTRL (rw):
    - [7:0] enable mask, reset value has the low NUM_DIGITS bits set.
    - [15:8] blink mask, reset 0.
    - [19:16] brightness, reset 4'hF.
    - Unused bits read as 0.
  - 2 BLINK_DIV (rw, reset BLINK_DIV_RST): number of cycles per blink half-period.
  - 3 STATUS (ro): bit 0 = blink phase (1 = on), bits [6:4] = current scan index. Writes to STATUS are ignored.
- Byte enables:
  - data_be_i[k] enables the write of byte k.
  - data_be_i = 0 on a write is treated as a full-word write.
- Blink:
  - The blink counter counts 0..BLINK_DIV-1. On wrap it returns to 0 and the phase toggles.
  - BLINK_DIV = 0 freezes the counter and holds the phase at on.
  - Any write to BLINK_DIV clears the counter and sets the phase to on, in the same cycle the register updates.
- PWM:
  - A 4-bit free-running counter produces the signal pwm_on = (pwm_cnt <= brightness).
  - brightness = 15 is always on; brightness = 0 gives a 1/16 duty cycle.
- Digit visibility: digit i is visible when enable[i] = 1, pwm_on = 1, and either blink[i] = 0 or the blink phase is on.
  - A visible digit shows the decoded segments of its nibble; an invisible digit shows 7'h7F.
- hex_o is registered and reflects a register write 2 cycles after the accepted request (register update, then output register).
- Scan:
  - The scan index advances every SCAN_DIV cycles and wraps from NUM_DIGITS-1 to 0.
  - dig_sel_o drives low only the bit at the current index; seg_o equals the hex_o slice for that index.
  - Both outputs are registered and change on the same edge.
- Reset asserted mid-operation clears everything asynchronously, including any pending rvalid.
- Segment encoding: bit order {g,f,e,d,c,b,a}, active-low. Value 0 is 7'h40, value F is 7'h0E.

Decomposition:
- rv_pkg additions:
  - Register offset constants HEX_REG_DATA = 0, HEX_REG_CTRL = 4, HEX_REG_BLINK_DIV = 8, HEX_REG_STATUS = 12.
  - A CTRL field struct typedef.
- Sub-module rv_hex7seg_decoder: combinational 4-bit to 7-bit active-low decoder, instantiated NUM_DIGITS times.

Test Plan:
- Reset, then read DATA, CTRL, BLINK_DIV and STATUS. Expect rvalid 1 cycle later, with values 0, 0x000F00FF, 25000000 and 0x1. Expect hex_o = 7'h40 on every digit 2 cycles after reset release.
- Write 0x12345678 to DATA with be = 4'b0000, then with be = 4'b0001 write 0x000000AB. Expect a readback of 0x123456AB; hex_o digit 0 = 7'h03 (b) and digit 1 = 7'h08 (A).
- Write CTRL = 0x000F0005. Expect digits 1, 3 and 5..7 at 7'h7F, and digits 0 and 2 decoded.
- Write BLINK_DIV = 4 and CTRL blink mask = 0x01. Expect digit 0 to alternate between decoded and blank every 4 cycles, and STATUS bit 0 to track the phase.
- With brightness = 3, expect every enabled digit visible 4 of every 16 cycles. With brightness = 15, expect every enabled digit always visible.
- With NUM_DIGITS = 4 and SCAN_DIV = 2, expect dig_sel_o to cycle through 1110, 1101, 1011, 0111, each for 2 cycles. Expect seg_o to match the selected hex_o slice. Expect a request at an address outside the window to produce no rvalid.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared bus widths, hex display register map and CTRL field layout.
package rv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = XLEN / 8;

    localparam logic [3:0] HEX_REG_DATA      = 4'd0;
    localparam logic [3:0] HEX_REG_CTRL      = 4'd4;
    localparam logic [3:0] HEX_REG_BLINK_DIV = 4'd8;
    localparam logic [3:0] HEX_REG_STATUS    = 4'd12;

    typedef struct packed {
        logic [11:0] rsvd;
        logic [3:0]  bright;
        logic [7:0]  blink;
        logic [7:0]  enable;
    } hex_ctrl_t;

    // Byte-lane merge; an all-zero enable means a full-word write.
    function automatic logic [XLEN-1:0] merge_be(input logic [XLEN-1:0] old_v,
                                                 input logic [XLEN-1:0] new_v,
                                                 input logic [BE_W-1:0] be);
        logic [XLEN-1:0] res;
        for (int k = 0; k < int'(BE_W); k++) begin
            res[8*k +: 8] = (be == '0 || be[k]) ? new_v[8*k +: 8] : old_v[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/rv_hex7seg_decoder.sv
// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module rv_hex7seg_decoder (
    input  logic [3:0] val,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = 7'h7F;
        case (val)
            4'h0: seg_c = 7'h40;
            4'h1: seg_c = 7'h79;
            4'h2: seg_c = 7'h24;
            4'h3: seg_c = 7'h30;
            4'h4: seg_c = 7'h19;
            4'h5: seg_c = 7'h12;
            4'h6: seg_c = 7'h02;
            4'h7: seg_c = 7'h78;
            4'h8: seg_c = 7'h00;
            4'h9: seg_c = 7'h10;
            4'hA: seg_c = 7'h08;
            4'hB: seg_c = 7'h03;
            4'hC: seg_c = 7'h46;
            4'hD: seg_c = 7'h21;
            4'hE: seg_c = 7'h06;
            4'hF: seg_c = 7'h0E;
            default: seg_c = 7'h7F;
        endcase
    end

endmodule

// File: rtl/rv_seven_digit_device_mx.sv
// Memory-mapped multi-digit seven-segment controller with blink, PWM dimming
// and a multiplexed scan output next to the static per-digit outputs.
module rv_seven_digit_device_mx
    import rv_pkg::*;
#(
    parameter int unsigned     NUM_DIGITS    = 8,
    parameter logic [XLEN-1:0] BASE_ADDR     = 32'h1000_0100,
    parameter int unsigned     SCAN_DIV      = 50000,
    parameter logic [XLEN-1:0] BLINK_DIV_RST = 32'd25000000
) (
    input  logic                    clk,
    input  logic                    arstn_i,
    input  logic                    data_req_i,
    input  logic                    data_we_i,
    input  logic [BE_W-1:0]         data_be_i,
    input  logic [XLEN-1:0]         data_addr_i,
    input  logic [XLEN-1:0]         data_wdata_i,
    output logic                    data_rvalid_o,
    output logic [XLEN-1:0]         data_rdata_o,
    output logic [NUM_DIGITS*7-1:0] hex_o,
    output logic [6:0]              seg_o,
    output logic [NUM_DIGITS-1:0]   dig_sel_o
);

    localparam int unsigned DATA_W = NUM_DIGITS * 4;
    localparam int unsigned HEX_W  = NUM_DIGITS * 7;
    localparam int unsigned SCAN_W = $clog2(SCAN_DIV + 1);
    localparam logic [7:0]  EN_RST = 8'((16'd1 << NUM_DIGITS) - 16'd1);

    logic [DATA_W-1:0] data_q;
    hex_ctrl_t         ctrl_q;
    logic [XLEN-1:0]   bdiv_q;
    logic [XLEN-1:0]   bcnt_q;
    logic              phase_q;
    logic [3:0]        pwm_q;
    logic [SCAN_W-1:0] scan_cnt_q;
    logic [2:0]        scan_idx_q;

    logic            hit_c;
    logic            wr_c;
    logic [3:0]      reg_off_c;
    logic [XLEN-1:0] rd_c;
    logic [XLEN-1:0] wmerge_c;
    logic            pwm_on_c;
    logic [HEX_W-1:0] hex_c;
    logic [6:0]      seg_sel_c;
    logic [NUM_DIGITS-1:0] dig_sel_c;
    logic            unused_c;

    assign hit_c     = data_req_i && (data_addr_i[XLEN-1:4] == BASE_ADDR[XLEN-1:4]);
    assign wr_c      = hit_c && data_we_i;
    assign reg_off_c = {data_addr_i[3:2], 2'b00};
    assign unused_c  = ^data_addr_i[1:0];
    assign wmerge_c  = merge_be(rd_c, data_wdata_i, data_be_i);
    assign pwm_on_c  = (pwm_q <= ctrl_q.bright);

    // Register read mux, also the old value for partial-byte writes.
    always_comb begin
        rd_c = '0;
        case (reg_off_c)
            HEX_REG_DATA:      rd_c = XLEN'(data_q);
            HEX_REG_CTRL:      rd_c = ctrl_q;
            HEX_REG_BLINK_DIV: rd_c = bdiv_q;
            HEX_REG_STATUS:    rd_c = XLEN'({scan_idx_q, 3'b000, phase_q});
            default:           rd_c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge arstn_i) begin
        if (!arstn_i) begin
            data_q <= '0;
            ctrl_q <= hex_ctrl_t'({12'd0, 4'hF, 8'd0, EN_RST});
        end else if (wr_c) begin
            if (reg_off_c == HEX_REG_DATA) begin
                data_q <= wmerge_c[DATA_W-1:0];
            end
            if (reg_off_c == HEX_REG_CTRL) begin
                ctrl_q <= hex_ctrl_t'({12'd0, wmerge_c[19:0]});
            end
        end
    end

    // Blink divider; a BLINK_DIV write restarts the half-period in the on phase.
    always_ff @(posedge clk or negedge arstn_i) begin
        if (!arstn_i) begin
            bdiv_q  <= BLINK_DIV_RST;
            bcnt_q  <= '0;
            phase_q <= 1'b1;
        end else if (wr_c && reg_off_c == HEX_REG_BLINK_DIV) begin
            bdiv_q  <= wmerge_c;
            bcnt_q  <= '0;
            phase_q <= 1'b1;
        end else if (bdiv_q == '0) begin
            phase_q <= 1'b1;
        end else if (bcnt_q >= bdiv_q - XLEN'(1)) begin
            bcnt_q  <= '0;
            phase_q <= ~phase_q;
        end else begin
            bcnt_q  <= bcnt_q + XLEN'(1);
        end
    end

    always_ff @(posedge clk or negedge arstn_i) begin
        if (!arstn_i) begin
            pwm_q      <= '0;
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
        end else begin
            pwm_q <= pwm_q + 4'd1;
            if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
                scan_cnt_q <= '0;
                scan_idx_q <= (scan_idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : scan_idx_q + 3'd1;
            end else begin
                scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
            end
        end
    end

    for (genvar i = 0; i < int'(NUM_DIGITS); i++) begin : g_digit
        logic [6:0] dec_c;
        logic       vis_c;

        rv_hex7seg_decoder u_dec (
            .val   (data_q[4*i +: 4]),
            .seg_c (dec_c)
        );

        assign vis_c = ctrl_q.enable[i] && pwm_on_c && (!ctrl_q.blink[i] || phase_q);
        assign hex_c[7*i +: 7] = vis_c ? dec_c : 7'h7F;
    end

    // Pick the scanned digit's segments and its active-low select line.
    always_comb begin
        seg_sel_c = 7'h7F;
        dig_sel_c = '1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (scan_idx_q == 3'(i)) begin
                seg_sel_c    = hex_c[7*i +: 7];
                dig_sel_c[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge arstn_i) begin
        if (!arstn_i) begin
            data_rvalid_o <= 1'b0;
            data_rdata_o  <= '0;
            hex_o         <= '1;
            seg_o         <= '1;
            dig_sel_o     <= '1;
        end else begin
            data_rvalid_o <= hit_c;
            data_rdata_o  <= (hit_c && !data_we_i) ? rd_c : '0;
            hex_o         <= hex_c;
            seg_o         <= seg_sel_c;
            dig_sel_o     <= dig_sel_c;
        end
    end

endmodule

// File: tb/tb_rv_seven_digit_device_mx.sv
// Randomised bus traffic against a behavioural display model, two configurations
// (8 digits / scan 5, 4 digits / scan 2) sharing one bus.
module tb_rv_seven_digit_device_mx;

    localparam logic [31:0] BASE = 32'h1000_0100;

    logic        clk;
    logic        arstn;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic        rvalid8, rvalid4;
    logic [31:0] rdata8, rdata4;
    logic [55:0] hex8;
    logic [27:0] hex4;
    logic [6:0]  seg8, seg4;
    logic [7:0]  dsel8;
    logic [3:0]  dsel4;

    int n_pass  = 0;
    int n_total = 0;

    rv_seven_digit_device_mx #(
        .NUM_DIGITS(8), .BASE_ADDR(BASE), .SCAN_DIV(5), .BLINK_DIV_RST(32'd25000000)
    ) dut8 (
        .clk(clk), .arstn_i(arstn), .data_req_i(req), .data_we_i(we), .data_be_i(be),
        .data_addr_i(addr), .data_wdata_i(wdata), .data_rvalid_o(rvalid8),
        .data_rdata_o(rdata8), .hex_o(hex8), .seg_o(seg8), .dig_sel_o(dsel8)
    );

    rv_seven_digit_device_mx #(
        .NUM_DIGITS(4), .BASE_ADDR(BASE), .SCAN_DIV(2), .BLINK_DIV_RST(32'd25000000)
    ) dut4 (
        .clk(clk), .arstn_i(arstn), .data_req_i(req), .data_we_i(we), .data_be_i(be),
        .data_addr_i(addr), .data_wdata_i(wdata), .data_rvalid_o(rvalid4),
        .data_rdata_o(rdata4), .hex_o(hex4), .seg_o(seg4), .dig_sel_o(dsel4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lit segments (active-high) per hex value; the display wants the complement.
    logic [6:0] seg_on [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic logic [6:0] seg7(input logic [3:0] n);
        return ~seg_on[n];
    endfunction

    function automatic int nd(input int k);
        return (k == 0) ? 8 : 4;
    endfunction

    function automatic int sd(input int k);
        return (k == 0) ? 5 : 2;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    endtask

    // Behavioural model state, one slot per configuration.
    logic [31:0] m_data [2];
    logic [31:0] m_ctrl [2];
    logic [31:0] m_bdiv [2];
    logic [31:0] m_bcnt [2];
    logic        m_phase [2];
    int          m_scnt [2];
    int          m_sidx [2];
    int          m_pwm;
    logic [63:0] e_hex [2];
    logic [6:0]  e_seg [2];
    logic [7:0]  e_dsel [2];
    logic        e_rv [2];
    logic [31:0] e_rd [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_data[k]  = 0;
            m_ctrl[k]  = 32'h000F_0000 | ((32'd1 << nd(k)) - 1);
            m_bdiv[k]  = 32'd25000000;
            m_bcnt[k]  = 0;
            m_phase[k] = 1'b1;
            m_scnt[k]  = 0;
            m_sidx[k]  = 0;
            e_hex[k]   = (64'd1 << (7 * nd(k))) - 1;
            e_seg[k]   = 7'h7F;
            e_dsel[k]  = 8'((16'd1 << nd(k)) - 1);
            e_rv[k]    = 1'b0;
            e_rd[k]    = 0;
        end
        m_pwm = 0;
    endtask

    // Advance the model by one clock edge using the bus inputs present now.
    task automatic model_step();
        logic hit, pwm_on, vis;
        logic [1:0]  off;
        logic [31:0] msk, regv, merged;
        logic [63:0] nh;
        hit = req && (addr[31:4] == BASE[31:4]);
        off = addr[3:2];
        msk = 0;
        for (int b = 0; b < 4; b++) if (be == 0 || be[b]) msk[8*b +: 8] = 8'hFF;
        pwm_on = 1'b0;
        for (int k = 0; k < 2; k++) begin
            pwm_on = (m_pwm <= int'(m_ctrl[k][19:16]));
            nh = 0;
            for (int i = 0; i < nd(k); i++) begin
                vis = m_ctrl[k][i] && pwm_on && (!m_ctrl[k][8+i] || m_phase[k]);
                nh[7*i +: 7] = vis ? seg7(m_data[k][4*i +: 4]) : 7'h7F;
            end
            e_hex[k]  = nh;
            e_seg[k]  = nh[7*m_sidx[k] +: 7];
            e_dsel[k] = 8'(((1 << nd(k)) - 1) & ~(1 << m_sidx[k]));
            case (off)
                2'd0:    regv = m_data[k];
                2'd1:    regv = m_ctrl[k];
                2'd2:    regv = m_bdiv[k];
                default: regv = {25'd0, 3'(m_sidx[k]), 3'd0, m_phase[k]};
            endcase
            e_rv[k] = hit;
            e_rd[k] = (hit && !we) ? regv : 32'd0;
            merged  = (regv & ~msk) | (wdata & msk);
            if (hit && we && off == 2'd2) begin
                m_bdiv[k] = merged; m_bcnt[k] = 0; m_phase[k] = 1'b1;
            end else if (m_bdiv[k] == 0) begin
                m_phase[k] = 1'b1;
            end else if (m_bcnt[k] + 1 == m_bdiv[k]) begin
                m_bcnt[k] = 0; m_phase[k] = !m_phase[k];
            end else begin
                m_bcnt[k] = m_bcnt[k] + 1;
            end
            if (hit && we && off == 2'd0) m_data[k] = merged & ((k == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF);
            if (hit && we && off == 2'd1) m_ctrl[k] = merged & 32'h000F_FFFF;
            m_scnt[k]++;
            if (m_scnt[k] == sd(k)) begin
                m_scnt[k] = 0;
                m_sidx[k] = (m_sidx[k] + 1) % nd(k);
            end
        end
        m_pwm = (m_pwm + 1) % 16;
    endtask

    // Every-cycle comparison of both configurations against the model.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!arstn) model_reset();
            chk("rvalid8", 64'(rvalid8), 64'(e_rv[0]));
            chk("rdata8",  64'(rdata8),  64'(e_rd[0]));
            chk("hex8",    64'(hex8),    e_hex[0]);
            chk("seg8",    64'(seg8),    64'(e_seg[0]));
            chk("dsel8",   64'(dsel8),   64'(e_dsel[0]));
            chk("rvalid4", 64'(rvalid4), 64'(e_rv[1]));
            chk("rdata4",  64'(rdata4),  64'(e_rd[1]));
            chk("hex4",    64'(hex4),    e_hex[1]);
            chk("seg4",    64'(seg4),    64'(e_seg[1]));
            chk("dsel4",   64'({4'd0, dsel4}), 64'(e_dsel[1]));
            if (arstn) model_step();
        end
    end

    task automatic cyc(input logic rq, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
        req = rq; we = w; be = b; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    logic [55:0] all40;
    int          cnt;

    initial begin
        arstn = 1'b0; req = 1'b0; we = 1'b0; be = 4'd0; addr = 32'd0; wdata = 32'd0;
        for (int i = 0; i < 8; i++) all40[7*i +: 7] = 7'h40;
        repeat (3) @(posedge clk);
        #1 arstn = 1'b1;

        // Reset values of every register
        cyc(1'b1, 1'b0, 4'd0, BASE + 32'h0, 32'd0);
        chk("lit_data_rst", 64'(rdata8), 64'h0);
        chk("lit_rvalid",   64'(rvalid8), 64'h1);
        cyc(1'b1, 1'b0, 4'd0, BASE + 32'h4, 32'd0);
        chk("lit_ctrl_rst8", 64'(rdata8), 64'h000F_00FF);
        chk("lit_ctrl_rst4", 64'(rdata4), 64'h000F_000F);
        cyc(1'b1, 1'b0, 4'd0, BASE + 32'h8, 32'd0);
        chk("lit_bdiv_rst", 64'(rdata8), 64'd25000000);
        cyc(1'b1, 1'b0, 4'd0, BASE + 32'hC, 32'd0);
        chk("lit_status_rst", 64'(rdata8), 64'h1);
        chk("lit_hex_rst", 64'(hex8), 64'(all40));

        // Full-word then single-byte write
        cyc(1'b1, 1'b1, 4'b0000, BASE + 32'h0, 32'h1234_5678);
        cyc(1'b1, 1'b1, 4'b0001, BASE + 32'h0, 32'h0000_00AB);
        cyc(1'b1, 1'b0, 4'd0, BASE + 32'h0, 32'd0);
        chk("lit_data_be", 64'(rdata8), 64'h1234_56AB);
        chk("lit_dig0_b", 64'(hex8[6:0]),  64'h03);
        chk("lit_dig1_A", 64'(hex8[13:7]), 64'h08);

        // Partial enable mask
        cyc(1'b1, 1'b1, 4'd0, BASE + 32'h4, 32'h000F_0005);
        idle();
        chk("lit_en_dig0", 64'(hex8[6:0]),   64'h03);
        chk("lit_en_dig1", 64'(hex8[13:7]),  64'h7F);
        chk("lit_en_dig2", 64'(hex8[20:14]), 64'h02);
        chk("lit_en_dig3", 64'(hex8[27:21]), 64'h7F);
        chk("lit_en_dig57", 64'(hex8[55:35]), 64'h1F_FFFF);

        // Blink digit 0 with a 4-cycle half-period
        cyc(1'b1, 1'b1, 4'd0, BASE + 32'h8, 32'd4);
        cyc(1'b1, 1'b1, 4'd0, BASE + 32'h4, 32'h000F_01FF);
        idle();
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (i % 3 == 0) cyc(1'b1, 1'b0, 4'd0, BASE + 32'hC, 32'd0);
            else idle();
            if (hex8[6:0] == 7'h7F) cnt++;
        end
        chk("lit_blink_dark", 64'(cnt), 64'd8);

        // PWM duty at brightness 3 and 15
        cyc(1'b1, 1'b1, 4'd0, BASE + 32'h4, 32'h0003_00FF);
        idle();
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            idle();
            if (hex8[6:0] != 7'h7F) cnt++;
        end
        chk("lit_pwm3", 64'(cnt), 64'd4);
        cyc(1'b1, 1'b1, 4'd0, BASE + 32'h4, 32'h000F_00FF);
        idle();
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            idle();
            if (hex8[6:0] != 7'h7F) cnt++;
        end
        chk("lit_pwm15", 64'(cnt), 64'd16);

        // Scan dwell on the 4-digit instance
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            idle();
            if (dsel4 == 4'b1110) cnt++;
        end
        chk("lit_scan_dwell", 64'(cnt), 64'd2);

        // Requests outside the window
        cyc(1'b1, 1'b0, 4'd0, BASE + 32'h100, 32'd0);
        chk("lit_miss_rvalid", 64'(rvalid8), 64'h0);
        cyc(1'b1, 1'b1, 4'd0, BASE ^ 32'h10, 32'hFFFF_FFFF);
        cyc(1'b1, 1'b0, 4'd0, BASE, 32'd0);
        chk("lit_miss_nowrite", 64'(rdata8), 64'h1234_56AB);

        // Randomised back-to-back traffic
        for (int n = 0; n < 1200; n++) begin
            logic [31:0] a, d;
            logic [1:0]  o;
            logic [3:0]  b;
            logic        w, r;
            r = ($urandom_range(0, 3) != 0);
            o = 2'($urandom_range(0, 3));
            w = 1'($urandom_range(0, 1));
            b = 4'($urandom);
            d = $urandom;
            a = BASE | {28'd0, o, 2'b00};
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else if ($urandom_range(0, 19) == 0) a = a ^ 32'h10;
            if (w && o == 2'd2) begin
                b = 4'd0;
                d = $urandom_range(0, 7);
            end
            cyc(r, w, b, a, d);
        end

        // Asynchronous reset with a response pending
        cyc(1'b1, 1'b0, 4'd0, BASE + 32'h4, 32'd0);
        chk("lit_pending_rvalid", 64'(rvalid8), 64'h1);
        #2 arstn = 1'b0;
        #1;
        chk("lit_arst_rvalid", 64'(rvalid8), 64'h0);
        chk("lit_arst_hex", 64'(hex8), 64'h00FF_FFFF_FFFF_FFFF);
        chk("lit_arst_dsel", 64'(dsel8), 64'hFF);
        @(posedge clk); #1;
        arstn = 1'b1;
        idle();
        idle();
        chk("lit_hex_after_rst", 64'(hex8), 64'(all40));
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
